// File: rtl/uart_rx_deserialiser.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserialiser
// Purpose  : Oversampled UART receiver: start/data/stop framing, LSB first.
//            Optional even-parity checking when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deserialiser #(
    parameter int DATAWIDTH  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    input  logic                 baud_tick,
    output logic [DATAWIDTH-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int c_cnt_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w = $clog2(DATAWIDTH);

    localparam logic [c_cnt_w-1:0] c_tick_zero = '0;
    localparam logic [c_cnt_w-1:0] c_tick_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_tick_half = c_cnt_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_tick_full = c_cnt_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0] c_bit_zero  = '0;
    localparam logic [c_bit_w-1:0] c_bit_one   = c_bit_w'(1);
    localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(DATAWIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY    = 3'd5
`endif
    } state_t;

    state_t                r_state;
    logic [1:0]            r_sync;
    logic [c_cnt_w-1:0]    r_tick_cnt;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [DATAWIDTH-1:0]  r_shift;
    logic                  w_line;
`ifdef UART_RX_PARITY_EN
    logic                  r_par_bit;
`endif

    assign w_line = r_sync[1];
    assign busy   = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= c_tick_zero;
            r_bit_cnt  <= c_bit_zero;
            r_shift    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (baud_tick) begin
                case (r_state)
                    S_IDLE: begin
                        r_tick_cnt <= c_tick_zero;
                        if (!w_line) begin
                            r_state <= S_START;
                        end
                    end
                    S_START: begin
                        // Half a bit after the edge we are at the start-bit centre.
                        if (r_tick_cnt == c_tick_half) begin
                            r_tick_cnt <= c_tick_zero;
                            r_bit_cnt  <= c_bit_zero;
                            r_state    <= w_line ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_tick_one;
                        end
                    end
                    S_DATA: begin
                        if (r_tick_cnt == c_tick_full) begin
                            r_tick_cnt <= c_tick_zero;
                            r_shift    <= {w_line, r_shift[DATAWIDTH-1:1]};
                            if (r_bit_cnt == c_bit_last) begin
                                r_bit_cnt <= c_bit_zero;
`ifdef UART_RX_PARITY_EN
                                r_state   <= S_PARITY;
`else
                                r_state   <= S_STOP;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_bit_one;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_tick_one;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (r_tick_cnt == c_tick_full) begin
                            r_tick_cnt <= c_tick_zero;
                            r_par_bit  <= w_line;
                            r_state    <= S_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_tick_one;
                        end
                    end
`endif
                    S_STOP: begin
                        if (r_tick_cnt == c_tick_full) begin
                            r_tick_cnt <= c_tick_zero;
                            if (w_line) begin
                                r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                                if ((^r_shift) ^ r_par_bit) begin
                                    parity_err <= 1'b1;
                                end else begin
                                    data_out   <= r_shift;
                                    data_valid <= 1'b1;
                                end
`else
                                data_out   <= r_shift;
                                data_valid <= 1'b1;
`endif
                            end else begin
                                frame_err <= 1'b1;
                                r_state   <= S_WAIT_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_tick_one;
                        end
                    end
                    S_WAIT_IDLE: begin
                        // A held-low break must not be mistaken for a new start bit.
                        r_tick_cnt <= c_tick_zero;
                        if (w_line) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_tick_cnt <= c_tick_zero;
                        r_state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserialiser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deserialiser
// Purpose  : Scoreboard bench for uart_rx_deserialiser with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserialiser;

    localparam int DW  = 8;
    localparam int OS  = 16;
    localparam int CPT = 4;           // clk cycles per baud_tick
    localparam int CPB = OS * CPT;    // clk cycles per bit

    localparam int c_k_valid  = 0;
    localparam int c_k_frame  = 1;
    localparam int c_k_parity = 2;

    typedef struct {
        int          kind;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_in = 1'b1;
    logic          baud_tick = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          busy;
    logic          w_perr;

    int            checks = 0;
    int            failures = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] model_last = '0;
    int            tick_div = 0;

    uart_rx_deserialiser #(.DATAWIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .baud_tick  (baud_tick),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (w_perr)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign w_perr = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_div  = (tick_div + 1) % CPT;
        baud_tick = (tick_div == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (data_valid || frame_err || w_perr)) begin
            int k;
            exp_t e;
            k = data_valid ? c_k_valid : (frame_err ? c_k_frame : c_k_parity);
            chk("pulse_onehot", 32'(int'(data_valid) + int'(frame_err) + int'(w_perr)), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(k), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", 32'(k), 32'(e.kind));
                chk("pulse_data_out", 32'(data_out), 32'(e.data));
            end
        end
    end

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Frame-level model: a good stop bit (and parity) updates the last word.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop,
                              input logic par_ok, input int gap);
        exp_t e;
        if (!stop) begin
            e.kind = c_k_frame;
        end else begin
`ifdef UART_RX_PARITY_EN
            e.kind = par_ok ? c_k_valid : c_k_parity;
`else
            e.kind = c_k_valid;
`endif
        end
        if (e.kind == c_k_valid) model_last = d;
        e.data = model_last;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ ~par_ok);
`endif
        send_bit(stop);
        for (int i = 0; i < gap; i++) send_bit(1'b1);
    endtask

    initial begin
        logic [DW-1:0] w5a;
        repeat (3) @(negedge clk);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(data_valid), 32'd0);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b1, 1);
        chk("a5_data_out", 32'(data_out), 32'hA5);
        chk("a5_busy_after", 32'(busy), 32'd0);

        // Short glitch on the line must be rejected silently.
        rx_in = 1'b0;
        repeat (4 * CPT) @(negedge clk);
        chk("glitch_busy_during", 32'(busy), 32'd1);
        rx_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_busy_after", 32'(busy), 32'd0);
        chk("glitch_data_out", 32'(data_out), 32'hA5);

        // Framing error followed by a held break.
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        rx_in = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        chk("break_wait_idle_busy", 32'(busy), 32'd1);
        chk("break_data_out", 32'(data_out), 32'hA5);
        rx_in = 1'b1;
        repeat (CPB) @(negedge clk);
        chk("break_released_busy", 32'(busy), 32'd0);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 1'b1, 1);
        chk("b2b_data_out", 32'(data_out), 32'hFF);

        // Reset during bit 4 of 0x5A discards the partial word.
        w5a = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(w5a[i]);
        rx_in = w5a[4];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_data_out", 32'(data_out), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        model_last = '0;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);
        chk("postreset_data_out", 32'(data_out), 32'd0);
        send_frame(8'h81, 1'b1, 1'b1, 1);
        chk("post_81_data_out", 32'(data_out), 32'h81);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1);
        chk("par_good_data_out", 32'(data_out), 32'h07);
        send_frame(8'h07, 1'b1, 1'b0, 1);
        chk("par_bad_data_out", 32'(data_out), 32'h07);
`endif

        // Randomised traffic against the frame-level model.
        for (int n = 0; n < 24; n++) begin
            logic [DW-1:0] d;
            logic          stop;
            logic          pok;
            int            gap;
            d    = DW'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            pok  = ($urandom_range(0, 3) != 0);
            gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send_frame(d, stop, pok, gap);
        end
        repeat (2 * CPB) @(negedge clk);
        chk("final_data_out", 32'(data_out), 32'(model_last));
        chk("final_busy", 32'(busy), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
